// File: rtl/weather_pkg.sv
// weather_pkg: shared sensor widths, saturating increment and publish FSM states
package weather_pkg;
  localparam int SENSOR_W = 8;
  localparam logic [SENSOR_W-1:0] SENSOR_MAX = 8'hFF;
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} pub_state_e;
  function automatic logic [SENSOR_W-1:0] sat_inc(input logic [SENSOR_W-1:0] v, input logic en);
    return (en && v != SENSOR_MAX) ? v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/contact_debouncer.sv
// contact_debouncer: 3-flop synchroniser, stability-count debounce and rising-edge tick for one contact
module contact_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic tick
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [2:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_q;
  logic          r_tick;
  logic          w_diff;
  logic          w_flip;
  assign w_diff = r_sync[2] ^ r_level;
  assign w_flip = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[1:0], raw};
      r_cnt     <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      r_level   <= w_flip ? r_sync[2] : r_level;
      r_level_q <= r_level;
      r_tick    <= r_level && !r_level_q;
    end
  assign level = r_level;
  assign tick  = r_tick;
endmodule

// File: rtl/weather_sensor_sampler.sv
// weather_sensor_sampler: debounced wind/rain edge counters published to the SPI slave,
// with output updates held back while the synchronised chip select is low.
module weather_sensor_sampler
  import weather_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int WINDOW_MS       = 1000,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wind_pulse,
  input  logic                rain_tip,
  input  logic                cs,
  output logic [SENSOR_W-1:0] windsensor,
  output logic [SENSOR_W-1:0] watersensor,
  output logic                sample_valid,
  output logic                wind_sat
);
  localparam int WIN = CLK_HZ / 1000 * WINDOW_MS;
  localparam int WW  = $clog2(WIN);
  logic [WW-1:0]       r_win;
  logic [2:0]          r_cs_sync;
  logic [SENSOR_W-1:0] r_wind_cnt;
  logic [SENSOR_W-1:0] r_wind_shadow;
  logic [SENSOR_W-1:0] r_water_shadow;
  logic [SENSOR_W-1:0] r_windsensor;
  logic [SENSOR_W-1:0] r_watersensor;
  logic                r_wind_evt;
  logic                r_water_evt;
  logic                r_valid;
  logic                r_sat;
  pub_state_e          r_state;
  pub_state_e          w_next;
  logic                w_wind_tick;
  logic                w_rain_tick;
  logic                w_unused_wind_level;
  logic                w_unused_rain_level;
  logic                w_tc;
  logic                w_cs;
  logic                w_evt;
  logic                w_load;
  logic [SENSOR_W-1:0] w_wind_inc;
  contact_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wind (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (wind_pulse),
    .level (w_unused_wind_level),
    .tick  (w_wind_tick)
  );
  contact_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rain (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (rain_tip),
    .level (w_unused_rain_level),
    .tick  (w_rain_tick)
  );
  assign w_cs       = r_cs_sync[2];
  assign w_tc       = r_win == WW'(WIN - 1);
  assign w_evt      = r_wind_evt || r_water_evt;
  assign w_wind_inc = sat_inc(r_wind_cnt, w_wind_tick);
  // cs sync resets high so a reset never looks like an open SPI transaction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cs_sync      <= '1;
      r_win          <= '0;
      r_wind_cnt     <= '0;
      r_wind_shadow  <= '0;
      r_water_shadow <= '0;
      r_wind_evt     <= 1'b0;
      r_water_evt    <= 1'b0;
      r_sat          <= 1'b0;
    end else begin
      r_cs_sync      <= {r_cs_sync[1:0], cs};
      r_win          <= w_tc ? '0 : r_win + 1'b1;
      r_wind_cnt     <= w_tc ? '0 : w_wind_inc;
      r_wind_shadow  <= w_tc ? w_wind_inc : r_wind_shadow;
      r_sat          <= r_sat || (w_tc && w_wind_inc == SENSOR_MAX);
      r_wind_evt     <= w_tc;
      r_water_shadow <= sat_inc(r_water_shadow, w_rain_tick);
      r_water_evt    <= w_rain_tick;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = (r_state == IDLE) ? ((w_evt && !w_cs) ? PEND : IDLE) : (w_cs ? IDLE : PEND);
  always_comb w_load = w_cs && (r_state == PEND || w_evt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_windsensor  <= '0;
      r_watersensor <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_valid       <= w_load;
      r_windsensor  <= w_load ? r_wind_shadow : r_windsensor;
      r_watersensor <= w_load ? r_water_shadow : r_watersensor;
    end
  assign windsensor   = r_windsensor;
  assign watersensor  = r_watersensor;
  assign sample_valid = r_valid;
  assign wind_sat     = r_sat;
endmodule

// File: tb/tb_weather_sensor_sampler.sv
// tb_weather_sensor_sampler: directed stimulus against an event-schedule model of windows,
// publish arming and cs deferral, plus literal expectations; a second instance covers saturation.
`timescale 1ns/1ps
module tb_weather_sensor_sampler;
  localparam int W   = 1000;
  localparam int LAT = 9;
  logic clk = 1'b0, rst_n = 1'b0, wind = 1'b0, rain = 1'b0, cs = 1'b1;
  logic rst1_n = 1'b0, wind1 = 1'b0;
  logic [7:0] ws, rs, ws1, rs1;
  logic sv, sat, sv1, sat1;
  int checks = 0, failures = 0;
  int cyc = 0, rel = 0;
  bit in_rst = 1'b1, done1 = 1'b0;
  bit wev[int], rev[int], cs_hist[int];
  int m_wcnt, m_wsh, m_water, m_ws, m_rs;
  bit m_sat, m_armed, m_sv;

  always #5 clk = ~clk;

  weather_sensor_sampler #(.CLK_HZ(100_000), .WINDOW_MS(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .wind_pulse(wind), .rain_tip(rain), .cs(cs),
    .windsensor(ws), .watersensor(rs), .sample_valid(sv), .wind_sat(sat)
  );
  weather_sensor_sampler #(.CLK_HZ(100_000), .WINDOW_MS(40), .DEBOUNCE_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .wind_pulse(wind1), .rain_tip(1'b0), .cs(1'b1),
    .windsensor(ws1), .watersensor(rs1), .sample_valid(sv1), .wind_sat(sat1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit cs_sync(input int e);
    return (e - 2 > rel) ? cs_hist[e-2] : 1'b1;
  endfunction

  function automatic int sat8(input int v);
    return v > 255 ? 255 : v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    cs_hist[cyc] = cs;
  end

  // Model: a tick latched at edge e belongs to window ceil((e-rel)/W); any window end or
  // rain tick arms a publish that fires on the first edge whose previous cycle saw cs_sync high.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_rst = 1'b1; m_wcnt = 0; m_wsh = 0; m_water = 0; m_ws = 0; m_rs = 0;
      m_sat = 1'b0; m_armed = 1'b0; m_sv = 1'b0;
    end else if (in_rst) begin
      in_rst = 1'b0;
      rel = cyc;
    end else begin
      m_sv = m_armed && cs_sync(cyc - 1);
      if (m_sv) begin
        m_ws = m_wsh; m_rs = m_water; m_armed = 1'b0;
      end
      if ((cyc - rel) % W == 0) begin
        m_wsh = sat8(m_wcnt + int'(wev.exists(cyc)));
        m_sat = m_sat | (m_wsh == 255);
        m_wcnt = 0;
        m_armed = 1'b1;
      end else m_wcnt = sat8(m_wcnt + int'(wev.exists(cyc)));
      if (rev.exists(cyc)) begin
        m_water = sat8(m_water + 1);
        m_armed = 1'b1;
      end
    end
    chk("cmp_windsensor", ws, m_ws);
    chk("cmp_watersensor", rs, m_rs);
    chk("cmp_sample_valid", sv, m_sv);
    chk("cmp_wind_sat", sat, m_sat);
  end

  task automatic at(input int t);
    while (cyc < rel + t) @(negedge clk);
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) wind = v;
    else if (which == 1) rain = v;
    else wind1 = v;
  endtask

  task automatic pulse(input int which, input int hi, input int lo);
    drive(which, 1'b1);
    if (which == 0) wev[cyc + LAT] = 1'b1;
    if (which == 1) rev[cyc + LAT] = 1'b1;
    repeat (hi) @(negedge clk);
    drive(which, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #2 rst1_n = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    repeat (260) pulse(2, 5, 5);
    while (cyc < 2700) @(negedge clk);
    chk("sat1_before_capture", sat1, 0);
    chk("ws1_before_capture", ws1, 0);
    while (cyc < 4006) @(negedge clk);
    chk("sat1_strobe", sv1, 1);
    chk("sat1_windsensor", ws1, 255);
    chk("sat1_flag", sat1, 1);
    while (cyc < 8006) @(negedge clk);
    chk("sat1_empty_ws", ws1, 0);
    chk("sat1_sticky", sat1, 1);
    chk("sat1_water", rs1, 0);
    done1 = 1'b1;
  end

  initial begin
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_ws", ws, 0); chk("rst_rs", rs, 0); chk("rst_sv", sv, 0); chk("rst_sat", sat, 0);
    @(negedge clk); @(negedge clk);
    at(1000); chk("win1_early_sv", sv, 0);
    at(1001); chk("win1_sv", sv, 1); chk("win1_ws", ws, 0);
    at(1010); repeat (7) pulse(0, 20, 20);
    at(2001); chk("seven_sv", sv, 1); chk("seven_ws", ws, 7);
    at(2002); chk("seven_sv_one_cycle", sv, 0);
    at(2100);
    wind = 1'b1; repeat (3) @(negedge clk); wind = 1'b0; repeat (3) @(negedge clk);
    wind = 1'b1; repeat (3) @(negedge clk); wind = 1'b0; repeat (3) @(negedge clk);
    pulse(0, 20, 20);
    at(3001); chk("bounce_ws", ws, 1);
    at(4001); chk("empty_sv", sv, 1); chk("empty_ws", ws, 0);
    at(4000);
    fork
      repeat (300) pulse(0, 8, 8);
      begin
        at(5001); chk("win62_ws", ws, 62);
        at(6001); chk("win63_ws", ws, 63);
      end
    join
    at(9100);
    fork
      pulse(1, 20, 20);
      begin
        at(9109); chk("rain1_early_sv", sv, 0);
        at(9110); chk("rain1_sv", sv, 1); chk("rain1_rs", rs, 1);
      end
    join
    pulse(1, 20, 20); chk("rain2_rs", rs, 2);
    pulse(1, 20, 20); chk("rain3_rs", rs, 3);
    fork
      repeat (258) pulse(1, 5, 5);
      begin at(10991); pulse(0, 10, 10); end
    join
    chk("rain_sat_rs", rs, 255);
    at(11001); chk("tc_tick_ws", ws, 1);
    at(12001); chk("win12_ws", ws, 0);
    at(12500);
    fork
      repeat (5) pulse(0, 10, 10);
      begin at(12900); cs = 1'b0; end
    join
    at(13001); chk("spi_hold_sv", sv, 0); chk("spi_hold_ws", ws, 0);
    at(13199); chk("spi_hold_late_ws", ws, 0);
    at(13200); cs = 1'b1;
    at(13203); chk("spi_release_early_sv", sv, 0);
    at(13204); chk("spi_release_sv", sv, 1); chk("spi_release_ws", ws, 5);
    at(13300); repeat (3) pulse(0, 10, 10);
    at(13900); cs = 1'b0;
    at(14001); chk("spi2_hold_ws", ws, 5);
    at(14300); repeat (2) pulse(0, 10, 10);
    at(15100); chk("spi2_hold_late_ws", ws, 5);
    at(15200); cs = 1'b1;
    at(15204); chk("spi2_newest_sv", sv, 1); chk("spi2_newest_ws", ws, 2);
    at(15205); chk("spi2_single_strobe", sv, 0);
    at(15300); repeat (4) pulse(0, 10, 10);
    at(15900); cs = 1'b0;
    at(16100);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ws", ws, 0); chk("async_rst_rs", rs, 0); chk("async_rst_sv", sv, 0);
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    at(10); repeat (2) pulse(0, 10, 10);
    fork
      begin at(992); pulse(0, 10, 10); end
      begin
        at(1000); chk("post_rst_early_sv", sv, 0);
        at(1001); chk("post_rst_sv", sv, 1); chk("post_rst_ws", ws, 2); chk("post_rst_rs", rs, 0);
        at(2001); chk("next_cycle_tick_ws", ws, 1);
      end
    join
    for (int i = 0; i < 20000 && !done1; i++) @(negedge clk);
    chk("dut1_done", done1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
